// File: rtl/uart_rx_frontend.sv
// UART receiver front end: pad resynchroniser, 3-sample glitch filter, loopback source mux
// and the 16x-oversampling enable generator driven by the divisor latch.
module uart_rx_frontend #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] dl,
    input  logic             dl_load,
    input  logic             loopback,
    input  logic             stx_pad_i,
    input  logic             srx_pad_i,
    output logic             enable,
    output logic             srx_sync,
    output logic             srx_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             filt_q, filt_d;
    logic                   loopback_q;
    logic                   mode_switch;
    logic                   filt_src;
    logic                   filt_stable;
    logic                   srx_sync_q, srx_sync_d;
    logic                   srx_prev_q;
    logic                   srx_fall_q, srx_fall_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic                   enable_q, enable_d;

    // Serial path: the sync chain always runs; loopback bypasses it because stx is
    // already in the clk domain.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], srx_pad_i};
        mode_switch = loopback ^ loopback_q;
        filt_src    = loopback ? stx_pad_i : sync_q[SYNC_STAGES-1];
        filt_stable = (filt_q == 3'b000) || (filt_q == 3'b111);

        if (mode_switch) begin
            // Re-arm the filter at idle so a mode change never looks like a start bit.
            filt_d     = 3'b111;
            srx_sync_d = 1'b1;
        end else begin
            filt_d     = {filt_q[1:0], filt_src};
            srx_sync_d = filt_stable ? filt_q[0] : srx_sync_q;
        end

        srx_fall_d = srx_prev_q & ~srx_sync_q;
    end

    // Baud down-counter: reload on load, on start-up from zero, and on reaching one.
    always_comb begin
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        if (dl == '0) begin
            cnt_d = '0;
        end else if (dl_load) begin
            cnt_d = dl;
        end else if (cnt_q == '0) begin
            cnt_d = dl;
        end else if (cnt_q == DIV_W'(1)) begin
            enable_d = 1'b1;
            cnt_d    = dl;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            sync_q     <= '1;
            filt_q     <= 3'b111;
            loopback_q <= 1'b0;
            srx_sync_q <= 1'b1;
            srx_prev_q <= 1'b1;
            srx_fall_q <= 1'b0;
            cnt_q      <= '0;
            enable_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            loopback_q <= loopback;
            srx_sync_q <= srx_sync_d;
            srx_prev_q <= srx_sync_q;
            srx_fall_q <= srx_fall_d;
            cnt_q      <= cnt_d;
            enable_q   <= enable_d;
        end
    end

    assign enable   = enable_q;
    assign srx_sync = srx_sync_q;
    assign srx_fall = srx_fall_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: event-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_rx_frontend;

    localparam int DIV_W       = 16;
    localparam int SYNC_STAGES = 2;

    logic             clk;
    logic             wb_rst_i;
    logic [DIV_W-1:0] dl;
    logic             dl_load;
    logic             loopback;
    logic             stx_pad_i;
    logic             srx_pad_i;
    logic             enable;
    logic             srx_sync;
    logic             srx_fall;

    uart_rx_frontend #(
        .DIV_W      (DIV_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .dl       (dl),
        .dl_load  (dl_load),
        .loopback (loopback),
        .stx_pad_i(stx_pad_i),
        .srx_pad_i(srx_pad_i),
        .enable   (enable),
        .srx_sync (srx_sync),
        .srx_fall (srx_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: pad seen through a delay queue, filter as a run-length of equal
    // samples, fall pulse as "one edge after a model 1->0", baud as scheduled fire times.
    int  cyc_n = 0;
    bit  started = 0;
    bit  m_sync, m_fall, m_en;
    bit  run_val;
    int  run_len;
    bit  lb_prev;
    bit  dq[$];
    bit  armed;
    int  next_fire;
    int  fall_at;
    bit  pad_old, src, new_sync;

    always @(posedge clk) begin
        cyc_n++;
        started = 1;
        if (wb_rst_i) begin
            m_sync  = 1; m_fall = 0; m_en = 0;
            run_val = 1; run_len = 3; lb_prev = 0;
            armed   = 0; next_fire = 0; fall_at = -10;
            dq.delete();
            repeat (SYNC_STAGES) dq.push_back(1'b1);
        end else begin
            pad_old = dq.pop_front();
            dq.push_back(srx_pad_i);
            src = loopback ? stx_pad_i : pad_old;
            if (loopback != lb_prev) begin
                new_sync = 1; run_val = 1; run_len = 3;
            end else begin
                new_sync = (run_len >= 3) ? run_val : m_sync;
                if (src == run_val) begin
                    if (run_len < 3) run_len++;
                end else begin
                    run_val = src; run_len = 1;
                end
            end
            m_fall = (cyc_n == fall_at + 1);
            if (m_sync && !new_sync) fall_at = cyc_n;
            m_sync  = new_sync;
            lb_prev = loopback;

            if (dl == 0) begin
                armed = 0; m_en = 0;
            end else if (dl_load || !armed) begin
                armed = 1; next_fire = cyc_n + int'(dl); m_en = 0;
            end else if (cyc_n == next_fire) begin
                m_en = 1; next_fire = cyc_n + int'(dl);
            end else begin
                m_en = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_enable", enable, m_en);
            chk("model_srx_sync", srx_sync, m_sync);
            chk("model_srx_fall", srx_fall, m_fall);
        end
    end

    task automatic pulse_low(input int len, input int exp_lows, input int exp_falls,
                             input string nm);
        int lows  = 0;
        int falls = 0;
        srx_pad_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!srx_sync) lows++;
            if (srx_fall) falls++;
            if (k == len) srx_pad_i = 1'b1;
        end
        chk({nm, "_lows"}, lows, exp_lows);
        chk({nm, "_falls"}, falls, exp_falls);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, first, pos1, pos2, bad, falls;

        wb_rst_i  = 1'b1;
        dl        = '0;
        dl_load   = 1'b0;
        loopback  = 1'b0;
        stx_pad_i = 1'b1;
        srx_pad_i = 1'b0;

        // Reset released with the pad held low.
        repeat (3) @(negedge clk);
        chk("reset_enable", enable, 0);
        chk("reset_srx_sync", srx_sync, 1);
        chk("reset_srx_fall", srx_fall, 0);
        wb_rst_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("pad0_sync", srx_sync, (k >= 6) ? 0 : 1);
            chk("pad0_fall", srx_fall, (k == 7) ? 1 : 0);
        end
        srx_pad_i = 1'b1;
        repeat (12) @(negedge clk);

        // Glitch filter.
        pulse_low(2, 0, 0, "glitch2");
        pulse_low(3, 3, 1, "pulse3");
        pulse_low(4, 4, 1, "pulse4");

        // dl=5: first enable 5 edges after load, 20 pulses in 100 cycles.
        dl = 16'd5; dl_load = 1'b1;
        @(negedge clk);
        dl_load = 1'b0;
        cnt = 0; first = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (enable) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        chk("dl5_first", first, 5);
        chk("dl5_count100", cnt, 20);

        // Load coinciding with an expected pulse suppresses it.
        repeat (4) @(negedge clk);
        dl_load = 1'b1;
        @(negedge clk);
        dl_load = 1'b0;
        chk("load_suppress", enable, 0);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (enable && first == 0) first = k;
        end
        chk("after_suppress_gap", first, 5);

        // dl change without load takes effect at the next reload.
        dl = 16'd2;
        pos1 = 0; pos2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (enable) begin
                if (pos1 == 0) pos1 = k;
                else if (pos2 == 0) pos2 = k;
            end
        end
        chk("dl_change_first", pos1, 5);
        chk("dl_change_second", pos2, 7);

        // dl=0 disables, then dl=1 gives enable every cycle.
        dl = '0;
        cnt = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (enable) cnt++;
        end
        chk("dl0_count", cnt, 0);
        dl = 16'd1; dl_load = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) dl_load = 1'b0;
            chk("dl1_enable", enable, (k >= 2) ? 1 : 0);
        end

        // Loopback switch while the pad is low.
        srx_pad_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("pad_low_before_lb", srx_sync, 0);
        loopback = 1'b1; stx_pad_i = 1'b1;
        bad = 0; falls = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!srx_sync) bad++;
            if (srx_fall) falls++;
        end
        chk("lb_switch_low_cycles", bad, 0);
        chk("lb_switch_falls", falls, 0);
        stx_pad_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 4) chk("lb_latency", srx_sync, (k == 4) ? 0 : 1);
            srx_pad_i = k[0];
            if (k == 16) stx_pad_i = 1'b1;
        end
        repeat (10) @(negedge clk);
        loopback  = 1'b0;
        srx_pad_i = 1'b1;
        repeat (12) @(negedge clk);

        // Reset mid-frame with dl=3.
        dl = 16'd3; dl_load = 1'b1;
        @(negedge clk);
        dl_load = 1'b0;
        repeat (7) @(negedge clk);
        srx_pad_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("midframe_low", srx_sync, 0);
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("midreset_enable", enable, 0);
        chk("midreset_sync", srx_sync, 1);
        wb_rst_i  = 1'b0;
        srx_pad_i = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (enable && first == 0) first = k;
        end
        chk("release_first_enable", first, 4);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
